// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_e;

    localparam int unsigned PORT_CPU  = 0;
    localparam int unsigned PORT_HOST = 1;

    // Width able to hold 0..max_burst inclusive.
    function automatic int unsigned burst_cnt_w(input int unsigned max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the current owner keeps the grant for up to
// MAX_BURST consecutive accesses while the other port is also requesting.
module rr_arb2
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    localparam int unsigned    BW        = burst_cnt_w(MAX_BURST);
    localparam logic [BW-1:0]  BURST_MAX = BW'(MAX_BURST);

    owner_e          owner_q, owner_d;
    owner_e          last_q, last_d;
    owner_e          win;
    logic [BW-1:0]   burst_q, burst_d;
    logic            c_req_v, h_req_v;

    // Requests are masked while reset is held so nothing is granted in reset.
    assign c_req_v = req[PORT_CPU]  & rst;
    assign h_req_v = req[PORT_HOST] & rst;

    // Arbitration state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_NONE;
            last_q  <= OWN_HOST;
            burst_q <= '0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    // Winner selection, grant vector and next arbitration state.
    always_comb begin
        win     = OWN_NONE;
        owner_d = owner_q;
        last_d  = last_q;
        burst_d = burst_q;
        gnt     = '0;

        if (c_req_v && !h_req_v) begin
            win = OWN_CPU;
        end else if (h_req_v && !c_req_v) begin
            win = OWN_HOST;
        end else if (c_req_v && h_req_v) begin
            if (owner_q == OWN_NONE) begin
                win = (last_q == OWN_CPU) ? OWN_HOST : OWN_CPU;
            end else if (burst_q == BURST_MAX) begin
                win = (owner_q == OWN_CPU) ? OWN_HOST : OWN_CPU;
            end else begin
                win = owner_q;
            end
        end

        if (win == OWN_NONE) begin
            owner_d = OWN_NONE;
            burst_d = '0;
        end else begin
            if (win == owner_q) begin
                if (burst_q != BURST_MAX) begin
                    burst_d = burst_q + 1'b1;
                end
            end else begin
                owner_d = win;
                burst_d = BW'(1);
            end
            last_d = win;
        end

        gnt[PORT_CPU]  = (win == OWN_CPU);
        gnt[PORT_HOST] = (win == OWN_HOST);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store path and a
// host loader/reader; muxes the granted port onto memory and routes read data.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 20,
    parameter int unsigned MAX_BURST     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     c_req,
    input  logic                     c_we,
    input  logic                     c_be,
    input  logic [ADDRESS_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0]    c_wdata,
    output logic                     c_gnt,
    output logic                     c_stall,
    output logic                     c_rvalid,
    output logic [DATA_WIDTH-1:0]    c_rdata,
    input  logic                     h_req,
    input  logic                     h_we,
    input  logic                     h_be,
    input  logic [ADDRESS_WIDTH-1:0] h_addr,
    input  logic [DATA_WIDTH-1:0]    h_wdata,
    output logic                     h_gnt,
    output logic                     h_rvalid,
    output logic [DATA_WIDTH-1:0]    h_rdata,
    output logic                     m_re,
    output logic                     m_we,
    output logic                     m_be,
    output logic [ADDRESS_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0]    m_wdata,
    input  logic [DATA_WIDTH-1:0]    m_rdata
);

    logic [1:0]            req;
    logic [1:0]            gnt;
    owner_e                rd_pend_q, rd_pend_d;
    logic [DATA_WIDTH-1:0] c_rdata_q, h_rdata_q;

    assign req[PORT_CPU]  = c_req;
    assign req[PORT_HOST] = h_req;

    rr_arb2 #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign c_gnt   = gnt[PORT_CPU];
    assign h_gnt   = gnt[PORT_HOST];
    assign c_stall = rst & c_req & ~c_gnt;

    // Drive memory from the granted port only; idle strobes otherwise.
    always_comb begin
        m_re    = 1'b0;
        m_we    = 1'b0;
        m_be    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (c_gnt) begin
            m_re    = ~c_we;
            m_we    = c_we;
            m_be    = c_be;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (h_gnt) begin
            m_re    = ~h_we;
            m_we    = h_we;
            m_be    = h_be;
            m_addr  = h_addr;
            m_wdata = h_wdata;
        end
    end

    // Remember which port issued this cycle's read.
    always_comb begin
        rd_pend_d = OWN_NONE;
        if (c_gnt && !c_we) begin
            rd_pend_d = OWN_CPU;
        end else if (h_gnt && !h_we) begin
            rd_pend_d = OWN_HOST;
        end
    end

    // Pending-read tag and per-port held read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend_q <= OWN_NONE;
            c_rdata_q <= '0;
            h_rdata_q <= '0;
        end else begin
            rd_pend_q <= rd_pend_d;
            if (rd_pend_q == OWN_CPU) begin
                c_rdata_q <= m_rdata;
            end
            if (rd_pend_q == OWN_HOST) begin
                h_rdata_q <= m_rdata;
            end
        end
    end

    // Memory data arrives combinationally in the return cycle; held afterwards.
    assign c_rvalid = (rd_pend_q == OWN_CPU);
    assign h_rvalid = (rd_pend_q == OWN_HOST);
    assign c_rdata  = c_rvalid ? m_rdata : c_rdata_q;
    assign h_rdata  = h_rvalid ? m_rdata : h_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with MAX_BURST=4 and a read-data scoreboard.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        c_req, c_we, c_be;
    logic [19:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_gnt, c_stall, c_rvalid;
    logic [31:0] c_rdata;
    logic        h_req, h_we, h_be;
    logic [19:0] h_addr;
    logic [31:0] h_wdata;
    logic        h_gnt, h_rvalid;
    logic [31:0] h_rdata;
    logic        m_re, m_we, m_be;
    logic [19:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] cq[$];
    logic [31:0] hq[$];

    dmem_arbiter #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (20),
        .MAX_BURST     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .c_req    (c_req),
        .c_we     (c_we),
        .c_be     (c_be),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .c_gnt    (c_gnt),
        .c_stall  (c_stall),
        .c_rvalid (c_rvalid),
        .c_rdata  (c_rdata),
        .h_req    (h_req),
        .h_we     (h_we),
        .h_be     (h_be),
        .h_addr   (h_addr),
        .h_wdata  (h_wdata),
        .h_gnt    (h_gnt),
        .h_rvalid (h_rvalid),
        .h_rdata  (h_rdata),
        .m_re     (m_re),
        .m_we     (m_we),
        .m_be     (m_be),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents as a fixed function of address.
    function automatic logic [31:0] pattern(input logic [19:0] a);
        return (a == 20'h00010) ? 32'hCAFEBABE : {12'hA5C, a};
    endfunction

    // Memory model: read data valid one cycle after m_re.
    always @(posedge clk) begin
        m_rdata <= m_re ? pattern(m_addr) : 32'h0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive both ports, check returns from the previous cycle,
    // then grants and memory strobes; queue expected read data on a read grant.
    task automatic step(input string tag,
                        input logic cr, input logic cw, input logic [19:0] ca, input logic [31:0] cd,
                        input logic hr, input logic hw, input logic [19:0] ha, input logic [31:0] hd,
                        input logic ecg, input logic ehg);
        logic        exp_rv;
        logic [31:0] d;
        c_req = cr; c_we = cw; c_be = 1'b1; c_addr = ca; c_wdata = cd;
        h_req = hr; h_we = hw; h_be = 1'b0; h_addr = ha; h_wdata = hd;
        #2;
        exp_rv = (cq.size() != 0);
        chk({tag, ".c_rvalid"}, {31'b0, c_rvalid}, {31'b0, exp_rv});
        if (exp_rv) begin
            d = cq.pop_front();
            chk({tag, ".c_rdata"}, c_rdata, d);
        end
        exp_rv = (hq.size() != 0);
        chk({tag, ".h_rvalid"}, {31'b0, h_rvalid}, {31'b0, exp_rv});
        if (exp_rv) begin
            d = hq.pop_front();
            chk({tag, ".h_rdata"}, h_rdata, d);
        end
        chk({tag, ".c_gnt"}, {31'b0, c_gnt}, {31'b0, ecg});
        chk({tag, ".h_gnt"}, {31'b0, h_gnt}, {31'b0, ehg});
        chk({tag, ".c_stall"}, {31'b0, c_stall}, {31'b0, cr & ~ecg});
        if (ecg) begin
            chk({tag, ".m_rwe"}, {30'b0, m_re, m_we}, {30'b0, ~cw, cw});
            chk({tag, ".m_be"}, {31'b0, m_be}, 32'd1);
            chk({tag, ".m_addr"}, {12'b0, m_addr}, {12'b0, ca});
            if (cw) chk({tag, ".m_wdata"}, m_wdata, cd);
            else    cq.push_back(pattern(ca));
        end else if (ehg) begin
            chk({tag, ".m_rwe"}, {30'b0, m_re, m_we}, {30'b0, ~hw, hw});
            chk({tag, ".m_be"}, {31'b0, m_be}, 32'd0);
            chk({tag, ".m_addr"}, {12'b0, m_addr}, {12'b0, ha});
            if (hw) chk({tag, ".m_wdata"}, m_wdata, hd);
            else    hq.push_back(pattern(ha));
        end else begin
            chk({tag, ".m_idle"}, {30'b0, m_re, m_we}, 32'd0);
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_be = 1'b1; c_addr = 20'h00010; c_wdata = 32'h0;
        h_req = 1'b1; h_we = 1'b1; h_be = 1'b1; h_addr = 20'h00020; h_wdata = 32'h12345678;

        // Both requesting while in reset: everything quiet.
        @(negedge clk);
        #2;
        chk("rst.c_gnt",    {31'b0, c_gnt},    32'd0);
        chk("rst.h_gnt",    {31'b0, h_gnt},    32'd0);
        chk("rst.c_stall",  {31'b0, c_stall},  32'd0);
        chk("rst.c_rvalid", {31'b0, c_rvalid}, 32'd0);
        chk("rst.h_rvalid", {31'b0, h_rvalid}, 32'd0);
        chk("rst.m_strobe", {29'b0, m_re, m_we, m_be}, 32'd0);
        chk("rst.m_addr",   {12'b0, m_addr},   32'd0);
        chk("rst.m_wdata",  m_wdata,           32'd0);
        chk("rst.c_rdata",  c_rdata,           32'd0);
        chk("rst.h_rdata",  h_rdata,           32'd0);
        @(negedge clk);
        rst = 1'b1;

        // First tie after reset goes to the CPU, then the host.
        step("first", 1'b1, 1'b0, 20'h00010, 32'h0, 1'b1, 1'b1, 20'h00020, 32'h12345678, 1'b1, 1'b0);
        step("hostw", 1'b0, 1'b0, 20'h00010, 32'h0, 1'b1, 1'b1, 20'h00020, 32'h12345678, 1'b0, 1'b1);
        idle("idle0");
        chk("hold.c_rdata", c_rdata, 32'hCAFEBABE);

        // Continuous contention: CCCC HHHH CCCC.
        for (int i = 0; i < 12; i++) begin
            step($sformatf("burst%0d", i),
                 1'b1, 1'b1, 20'h00040, 32'hC0C00001,
                 1'b1, 1'b1, 20'h00080, 32'h40400002,
                 ((i / 4) % 2) == 0, ((i / 4) % 2) == 1);
        end
        idle("idle1");

        // Host alone: never forced to yield.
        for (int i = 0; i < 20; i++) begin
            step($sformatf("hsolo%0d", i),
                 1'b0, 1'b0, 20'h0, 32'h0,
                 1'b1, 1'b1, 20'(i * 4), 32'(i),
                 1'b0, 1'b1);
        end
        // Host burst count saturated at MAX_BURST: CPU wins immediately.
        step("sat", 1'b1, 1'b0, 20'h00030, 32'h0, 1'b1, 1'b1, 20'h00200, 32'h0BADF00D, 1'b1, 1'b0);
        step("satH", 1'b0, 1'b0, 20'h0, 32'h0, 1'b1, 1'b1, 20'h00200, 32'h0BADF00D, 1'b0, 1'b1);
        idle("idle2");

        // Alternating reads: each return one cycle after its own grant.
        step("altC1", 1'b1, 1'b0, 20'h00050, 32'h0, 1'b0, 1'b0, 20'h0, 32'h0, 1'b1, 1'b0);
        step("altH",  1'b0, 1'b0, 20'h0, 32'h0, 1'b1, 1'b0, 20'h00060, 32'h0, 1'b0, 1'b1);
        step("altC2", 1'b1, 1'b0, 20'h00070, 32'h0, 1'b0, 1'b0, 20'h0, 32'h0, 1'b1, 1'b0);
        idle("idle3");
        chk("hold.h_rdata", h_rdata, pattern(20'h00060));

        // Reset right after a host read grant: the return is dropped.
        step("prerst", 1'b0, 1'b0, 20'h0, 32'h0, 1'b1, 1'b0, 20'h00090, 32'h0, 1'b0, 1'b1);
        rst = 1'b0;
        c_req = 1'b1; h_req = 1'b1;
        cq.delete();
        hq.delete();
        #2;
        chk("mid.h_rvalid", {31'b0, h_rvalid}, 32'd0);
        chk("mid.gnt",      {30'b0, c_gnt, h_gnt}, 32'd0);
        chk("mid.m_strobe", {30'b0, m_re, m_we}, 32'd0);
        chk("mid.c_stall",  {31'b0, c_stall}, 32'd0);
        chk("mid.h_rdata",  h_rdata, 32'd0);
        @(negedge clk);
        #2;
        chk("mid2.h_rvalid", {31'b0, h_rvalid}, 32'd0);
        rst = 1'b1;
        // Arbitration state back to reset values: CPU wins the tie.
        step("post", 1'b1, 1'b0, 20'h000A0, 32'h0, 1'b1, 1'b0, 20'h000B0, 32'h0, 1'b1, 1'b0);
        step("postH", 1'b0, 1'b0, 20'h0, 32'h0, 1'b1, 1'b0, 20'h000B0, 32'h0, 1'b0, 1'b1);
        idle("idle4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
